// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
//   Round-robin arbiter that shares the bidirectional uio pad bus between
//   NUM_REQ requesters. It runs one transaction at a time. A write drives
//   uio_out for DRIVE_CYCLES cycles. A read releases the bus for TURNAROUND
//   cycles and then captures uio_in.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req/req_wr        per-requester level request and direction (1=write),
//                     sampled only at the arbitration edge
//   req_wdata         write data, requester i on bits [8i+7:8i]
//   gnt               one-hot grant, held through the DONE cycle
//   done/rvalid       last-cycle pulse; rvalid only on reads
//   rdata             last captured uio_in
//   busy              transaction in progress
//   uio_in/out/oe     pad interface
module uio_bus_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DRIVE_CYCLES = 1,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_wr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 done,
    output logic [7:0]           rdata,
    output logic                 rvalid,
    output logic                 busy,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe
);

    localparam int unsigned IW   = $clog2(NUM_REQ);
    localparam int unsigned MAXC = (DRIVE_CYCLES > TURNAROUND) ? DRIVE_CYCLES : TURNAROUND;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DRV_LAST  = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURNAROUND - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDrive   = 3'd1;
    localparam logic [2:0] StTurn    = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               wr_q, wr_d;
    logic [7:0]         out_q, out_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               found;
    logic [IW-1:0]      win;
    logic [7:0]         win_wdata;

    // Scan upward from rr_ptr+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        int unsigned cand;
        found = 1'b0;
        win   = rr_ptr_q;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    always_comb begin
        win_wdata = 8'h00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win) begin
                win_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        wr_d     = wr_q;
        out_d    = out_q;
        gnt_d    = gnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    rr_ptr_d = win;
                    gnt_d    = NUM_REQ'(1) << win;
                    wr_d     = req_wr[win];
                    cnt_d    = '0;
                    if (req_wr[win]) begin
                        // Pad output only changes when a new write is granted,
                        // so it holds the last driven value while released.
                        out_d   = win_wdata;
                        state_d = StDrive;
                    end else begin
                        state_d = StTurn;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == DRV_LAST) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StTurn: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCapture: begin
                rdata_d = uio_in;
                state_d = StDone;
            end
            StDone: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            wr_q     <= 1'b0;
            out_q    <= 8'h00;
            gnt_q    <= '0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            wr_q     <= wr_d;
            out_q    <= out_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign uio_oe  = (state_q == StDrive) ? 8'hFF : 8'h00;
    assign uio_out = out_q;
    assign gnt     = gnt_q;
    assign done    = (state_q == StDone);
    assign rvalid  = (state_q == StDone) && !wr_q;
    assign rdata   = rdata_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: default instance plus a
// DRIVE_CYCLES=3 / TURNAROUND=2 instance for the stretched timing case.
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req, req_wr, gnt;
    logic [31:0] req_wdata;
    logic [7:0]  uio_in, uio_out, uio_oe, rdata;
    logic        done, rvalid, busy;

    logic [3:0]  req2, req_wr2, gnt2;
    logic [31:0] req_wdata2;
    logic [7:0]  uio_in2, uio_out2, uio_oe2, rdata2;
    logic        done2, rvalid2, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    uio_bus_arbiter #(.NUM_REQ(4), .DRIVE_CYCLES(1), .TURNAROUND(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    uio_bus_arbiter #(.NUM_REQ(4), .DRIVE_CYCLES(3), .TURNAROUND(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_wr(req_wr2), .req_wdata(req_wdata2),
        .gnt(gnt2), .done(done2), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2),
        .uio_in(uio_in2), .uio_out(uio_out2), .uio_oe(uio_oe2)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'hF; req_wr = 4'hF; req_wdata = 32'h44332211;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got=%h exp=0", gnt); end
        n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rst_oe got=%h exp=00", uio_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
        n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL rst_out got=%h exp=00", uio_out); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
        n_cmp++; if (uio_out !== 8'h11) begin n_bad++; $display("FAIL rst_first_out got=%h exp=11", uio_out); end
        req = 4'h0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rst_first_done got=%b exp=1", done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_first_idle got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        req = 4'b0010; req_wr = 4'b0010; req_wdata = 32'h0000A500;
        @(negedge clk);
        n_cmp++; if (uio_oe !== 8'hFF) begin n_bad++; $display("FAIL wr_oe got=%h exp=FF", uio_oe); end
        n_cmp++; if (uio_out !== 8'hA5) begin n_bad++; $display("FAIL wr_out got=%h exp=A5", uio_out); end
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL wr_gnt1 got=%b exp=0010", gnt); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wr_done_early got=%b exp=0", done); end
        req = 4'h0; req_wdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL wr_oe_done got=%h exp=00", uio_oe); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wr_done got=%b exp=1", done); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL wr_gnt2 got=%b exp=0010", gnt); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle got=%b exp=0", busy); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL wr_gnt_clr got=%b exp=0000", gnt); end
        n_cmp++; if (uio_out !== 8'hA5) begin n_bad++; $display("FAIL wr_out_hold got=%h exp=A5", uio_out); end
    endtask

    task automatic test_read();
        req = 4'b0100; req_wr = 4'b0000;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rd_gnt got=%b exp=0100", gnt); end
        n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rd_turn_oe got=%h exp=00", uio_oe); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy got=%b exp=1", busy); end
        req = 4'h0; uio_in = 8'h3C;
        @(negedge clk);
        n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rd_cap_oe got=%h exp=00", uio_oe); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rd_cap_done got=%b exp=0", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rd_done got=%b exp=1", done); end
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid got=%b exp=1", rvalid); end
        n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata got=%h exp=3C", rdata); end
        uio_in = 8'h00;
        @(negedge clk);
        n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata_hold got=%h exp=3C", rdata); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_clr got=%b exp=0", rvalid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seen[$];
        logic [3:0] exp_seq[5];
        logic       prev_done;
        logic [3:0] prev_gnt;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        rst = 1'b1; req = 4'h0;
        @(negedge clk);
        rst = 1'b0; req = 4'hF; req_wr = 4'b0101; req_wdata = 32'h40302010;
        prev_done = 1'b0; prev_gnt = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (!$onehot0(gnt)) begin n_bad++; $display("FAIL rr_onehot got=%b", gnt); end
            if (prev_done) begin
                n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rr_oe_after_done got=%h exp=00", uio_oe); end
            end
            if (gnt !== 4'h0 && gnt !== prev_gnt) seen.push_back(gnt);
            prev_done = done; prev_gnt = gnt;
        end
        req = 4'h0;
        n_cmp++; if (seen.size() < 5) begin n_bad++; $display("FAIL rr_count got=%0d exp>=5", seen.size()); end
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] !== exp_seq[i]) begin n_bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, seen[i], exp_seq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1; req = 4'h0;
        @(negedge clk);
        rst = 1'b0; req = 4'b0010; req_wr = 4'b0010; req_wdata = 32'h00007700;
        @(negedge clk);
        n_cmp++; if (uio_oe !== 8'hFF) begin n_bad++; $display("FAIL rm_drive_oe got=%h exp=FF", uio_oe); end
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rm_drive_gnt got=%b exp=0010", gnt); end
        rst = 1'b1; req = 4'h0;
        @(negedge clk);
        n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rm_oe got=%h exp=00", uio_oe); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rm_gnt got=%b exp=0000", gnt); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rm_done got=%b exp=0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        rst = 1'b0; req = 4'b0011; req_wr = 4'b0011;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rm_restart got=%b exp=0001", gnt); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rm_done2 got=%b exp=0", done); end
        req = 4'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_idle got=%b exp=0", busy); end
    endtask

    task automatic test_long_timing();
        int ff_cnt;
        int done_n;
        // Write on requester 0.
        req2 = 4'b0001; req_wr2 = 4'b0001; req_wdata2 = 32'h0000005A;
        ff_cnt = 0; done_n = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req2 = 4'h0;
                n_cmp++; if (gnt2 !== 4'b0001) begin n_bad++; $display("FAIL lt_wr_gnt got=%b exp=0001", gnt2); end
            end
            if (uio_oe2 === 8'hFF) begin
                ff_cnt++;
                n_cmp++; if (uio_out2 !== 8'h5A) begin n_bad++; $display("FAIL lt_wr_out got=%h exp=5A", uio_out2); end
            end
            if (done2 === 1'b1 && done_n == 0) done_n = n;
        end
        n_cmp++; if (ff_cnt != 3) begin n_bad++; $display("FAIL lt_wr_ffcnt got=%0d exp=3", ff_cnt); end
        n_cmp++; if (done_n != 4) begin n_bad++; $display("FAIL lt_wr_done_cycle got=%0d exp=4", done_n); end
        // Read on requester 1.
        req2 = 4'b0010; req_wr2 = 4'b0000; uio_in2 = 8'hC3;
        ff_cnt = 0; done_n = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req2 = 4'h0;
                n_cmp++; if (gnt2 !== 4'b0010) begin n_bad++; $display("FAIL lt_rd_gnt got=%b exp=0010", gnt2); end
            end
            if (uio_oe2 !== 8'h00) ff_cnt++;
            if (done2 === 1'b1 && done_n == 0) begin
                done_n = n;
                n_cmp++; if (rvalid2 !== 1'b1) begin n_bad++; $display("FAIL lt_rd_rvalid got=%b exp=1", rvalid2); end
                n_cmp++; if (rdata2 !== 8'hC3) begin n_bad++; $display("FAIL lt_rd_rdata got=%h exp=C3", rdata2); end
            end
        end
        n_cmp++; if (ff_cnt != 0) begin n_bad++; $display("FAIL lt_rd_oe_cycles got=%0d exp=0", ff_cnt); end
        n_cmp++; if (done_n != 4) begin n_bad++; $display("FAIL lt_rd_done_cycle got=%0d exp=4", done_n); end
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; req_wr = 4'h0; req_wdata = 32'h0; uio_in = 8'h00;
        req2 = 4'h0; req_wr2 = 4'h0; req_wdata2 = 32'h0; uio_in2 = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_long_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
